// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared defaults, tag encoding and CDB bus slicing helpers
package rf_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREG_DEF  = 32;
    localparam int TAG_W_DEF = 4;

    localparam logic [TAG_W_DEF-1:0] TAG_NONE = '0;

    // Wide enough for 4 channels of 64-bit values; callers zero-extend into it.
    localparam int SLICE_MAX = 256;
    typedef logic [SLICE_MAX-1:0] slice_bus_t;

    function automatic slice_bus_t cdb_field(input slice_bus_t bus, input int ch, input int w);
        slice_bus_t mask;
        mask = (slice_bus_t'(1) << w) - slice_bus_t'(1);
        return (bus >> (ch * w)) & mask;
    endfunction

    function automatic slice_bus_t cdb_tag_of(input slice_bus_t bus, input int ch, input int tag_w);
        return cdb_field(bus, ch, tag_w);
    endfunction

    function automatic slice_bus_t cdb_val_of(input slice_bus_t bus, input int ch, input int xlen);
        return cdb_field(bus, ch, xlen);
    endfunction

    function automatic slice_bus_t cdb_idx_of(input slice_bus_t bus, input int ch, input int rw);
        return cdb_field(bus, ch, rw);
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one source operand read: dep lookup, CDB bypass, v/q select
module rf_read_port
    import rf_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREG  = NREG_DEF,
    parameter int TAG_W = TAG_W_DEF,
    parameter int NCDB  = 2,
    parameter int RW    = $clog2(NREG)
) (
    input  logic             en,
    input  logic [RW-1:0]    src,
    input  logic [XLEN-1:0]  val [NREG],
    input  logic [TAG_W-1:0] dep [NREG],
    input  logic [NCDB-1:0]  cdb_active,
    input  logic [TAG_W-1:0] ch_tag [NCDB],
    input  logic [XLEN-1:0]  ch_val [NCDB],
    output logic [XLEN-1:0]  v,
    output logic [TAG_W-1:0] q
);

    localparam logic [TAG_W-1:0] NONE = TAG_W'(TAG_NONE);

    logic [TAG_W-1:0] src_dep;
    logic             byp_hit;
    logic [XLEN-1:0]  byp_val;

    // Channel tags are unique per cycle, so at most one channel can hit.
    always_comb begin
        src_dep = dep[src];
        byp_hit = 1'b0;
        byp_val = '0;
        for (int c = 0; c < NCDB; c++) begin
            if (cdb_active[c] && ch_tag[c] == src_dep) begin
                byp_hit = 1'b1;
                byp_val = ch_val[c];
            end
        end
    end

    always_comb begin
        v = '0;
        q = NONE;
        if (en && src != '0) begin
            if (src_dep == NONE) begin
                v = val[src];
            end else if (byp_hit) begin
                v = byp_val;
            end else begin
                q = src_dep;
            end
        end
    end

endmodule

// File: rtl/regfile_multi_cdb.sv
// rtl/regfile_multi_cdb.sv - register file with rename tags and NCDB write-back channels
module regfile_multi_cdb
    import rf_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREG  = NREG_DEF,
    parameter int TAG_W = TAG_W_DEF,
    parameter int NCDB  = 2,
    parameter int RW    = $clog2(NREG),
    parameter int CNT_W = $clog2(NREG + 1)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  inst_valid,
    input  logic                  push_valid,
    input  logic [RW-1:0]         rd,
    input  logic [RW-1:0]         rs1,
    input  logic [RW-1:0]         rs2,
    input  logic [TAG_W-1:0]      rd_tag,
    input  logic [NCDB-1:0]       cdb_active,
    input  logic [NCDB*TAG_W-1:0] cdb_tag,
    input  logic [NCDB*XLEN-1:0]  cdb_val,
    input  logic [NCDB*RW-1:0]    cdb_rd_idx,
    input  logic                  predict_fail,
    output logic [XLEN-1:0]       vj,
    output logic [XLEN-1:0]       vk,
    output logic [TAG_W-1:0]      qj,
    output logic [TAG_W-1:0]      qk,
    output logic [CNT_W-1:0]      pending_cnt,
    output logic                  all_clear
);

    localparam logic [TAG_W-1:0] NONE = TAG_W'(TAG_NONE);

    logic [XLEN-1:0]  val     [NREG];
    logic [TAG_W-1:0] dep     [NREG];
    logic [XLEN-1:0]  val_nxt [NREG];
    logic [TAG_W-1:0] dep_nxt [NREG];
    logic [CNT_W-1:0] cnt_nxt;

    logic [TAG_W-1:0] ch_tag [NCDB];
    logic [XLEN-1:0]  ch_val [NCDB];
    logic [RW-1:0]    ch_idx [NCDB];

    logic rename;
    assign rename = inst_valid && push_valid && rd != '0;

    always_comb begin
        for (int c = 0; c < NCDB; c++) begin
            ch_tag[c] = TAG_W'(cdb_tag_of(slice_bus_t'(cdb_tag), c, TAG_W));
            ch_val[c] = XLEN'(cdb_val_of(slice_bus_t'(cdb_val), c, XLEN));
            ch_idx[c] = RW'(cdb_idx_of(slice_bus_t'(cdb_rd_idx), c, RW));
        end
    end

    rf_read_port #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .NCDB(NCDB), .RW(RW)) u_rd_j (
        .en         (inst_valid),
        .src        (rs1),
        .val        (val),
        .dep        (dep),
        .cdb_active (cdb_active),
        .ch_tag     (ch_tag),
        .ch_val     (ch_val),
        .v          (vj),
        .q          (qj)
    );

    rf_read_port #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .NCDB(NCDB), .RW(RW)) u_rd_k (
        .en         (inst_valid),
        .src        (rs2),
        .val        (val),
        .dep        (dep),
        .cdb_active (cdb_active),
        .ch_tag     (ch_tag),
        .ch_val     (ch_val),
        .v          (vk),
        .q          (qk)
    );

    // Ascending channel scan: later channels override, but a tag-matching
    // channel locks the value so nothing after it can displace it.
    always_comb begin
        logic matched;
        val_nxt = val;
        dep_nxt = dep;
        matched = 1'b0;
        if (predict_fail) begin
            for (int i = 0; i < NREG; i++) begin
                dep_nxt[i] = NONE;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                matched = 1'b0;
                for (int c = 0; c < NCDB; c++) begin
                    if (cdb_active[c] && int'(ch_idx[c]) == i) begin
                        if (dep[i] != NONE && ch_tag[c] == dep[i]) begin
                            val_nxt[i] = ch_val[c];
                            dep_nxt[i] = NONE;
                            matched    = 1'b1;
                        end else if (!matched) begin
                            val_nxt[i] = ch_val[c];
                        end
                    end
                end
                if (rename && int'(rd) == i) begin
                    dep_nxt[i] = rd_tag;
                end
            end
        end
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NREG; i++) begin
            if (dep_nxt[i] != NONE) begin
                cnt_nxt = cnt_nxt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NREG; i++) begin
                val[i] <= '0;
                dep[i] <= NONE;
            end
            pending_cnt <= '0;
            all_clear   <= 1'b1;
        end else if (rdy_in) begin
            val         <= val_nxt;
            dep         <= dep_nxt;
            pending_cnt <= cnt_nxt;
            all_clear   <= (cnt_nxt == '0);
        end
    end

endmodule

// File: tb/tb_regfile_multi_cdb.sv
// tb/tb_regfile_multi_cdb.sv - directed plus randomized check against a behavioural model
module tb_regfile_multi_cdb;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        inst_valid;
    logic        push_valid;
    logic [4:0]  rd, rs1, rs2;
    logic [3:0]  rd_tag;
    logic [1:0]  cdb_active;
    logic [7:0]  cdb_tag;
    logic [63:0] cdb_val;
    logic [9:0]  cdb_rd_idx;
    logic        predict_fail;
    logic [31:0] vj, vk;
    logic [3:0]  qj, qk;
    logic [5:0]  pending_cnt;
    logic        all_clear;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_val [32];
    logic [3:0]  m_dep [32];

    regfile_multi_cdb #(.XLEN(32), .NREG(32), .TAG_W(4), .NCDB(2)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .inst_valid   (inst_valid),
        .push_valid   (push_valid),
        .rd           (rd),
        .rs1          (rs1),
        .rs2          (rs2),
        .rd_tag       (rd_tag),
        .cdb_active   (cdb_active),
        .cdb_tag      (cdb_tag),
        .cdb_val      (cdb_val),
        .cdb_rd_idx   (cdb_rd_idx),
        .predict_fail (predict_fail),
        .vj           (vj),
        .vk           (vk),
        .qj           (qj),
        .qk           (qk),
        .pending_cnt  (pending_cnt),
        .all_clear    (all_clear)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        rdy_in = 1'b1; inst_valid = 1'b0; push_valid = 1'b0;
        rd = '0; rs1 = '0; rs2 = '0; rd_tag = '0;
        cdb_active = '0; cdb_tag = '0; cdb_val = '0; cdb_rd_idx = '0;
        predict_fail = 1'b0;
    endtask

    task automatic set_cdb(input int c, input logic a, input logic [3:0] t,
                           input logic [31:0] v, input logic [4:0] ix);
        cdb_active[c]        = a;
        cdb_tag[c*4 +: 4]    = t;
        cdb_val[c*32 +: 32]  = v;
        cdb_rd_idx[c*5 +: 5] = ix;
    endtask

    task automatic push(input logic [4:0] r, input logic [3:0] t);
        inst_valid = 1'b1; push_valid = 1'b1; rd = r; rd_tag = t;
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i] = '0;
            m_dep[i] = '0;
        end
    endfunction

    function automatic void mread(input logic [4:0] s, output logic [31:0] v, output logic [3:0] q);
        v = '0;
        q = '0;
        if (!inst_valid || s == 0) return;
        if (m_dep[s] == 0) begin
            v = m_val[s];
            return;
        end
        for (int c = 0; c < 2; c++) begin
            if (cdb_active[c] && cdb_tag[c*4 +: 4] == m_dep[s]) begin
                v = cdb_val[c*32 +: 32];
                return;
            end
        end
        q = m_dep[s];
    endfunction

    // Check combinational reads, clock once, then check registered count.
    task automatic cycle();
        logic [31:0] ev;
        logic [3:0]  eq;
        logic [31:0] nv [32];
        logic [3:0]  nd [32];
        int          pop;
        #1;
        mread(rs1, ev, eq);
        chk("vj", vj, ev);
        chk("qj", qj, eq);
        mread(rs2, ev, eq);
        chk("vk", vk, ev);
        chk("qk", qk, eq);
        nv = m_val;
        nd = m_dep;
        if (rdy_in) begin
            if (predict_fail) begin
                for (int i = 0; i < 32; i++) nd[i] = '0;
            end else begin
                for (int c = 0; c < 2; c++) begin
                    if (cdb_active[c] && cdb_rd_idx[c*5 +: 5] != 0)
                        nv[cdb_rd_idx[c*5 +: 5]] = cdb_val[c*32 +: 32];
                end
                for (int c = 0; c < 2; c++) begin
                    logic [4:0] ix;
                    ix = cdb_rd_idx[c*5 +: 5];
                    if (cdb_active[c] && ix != 0 && m_dep[ix] != 0 && cdb_tag[c*4 +: 4] == m_dep[ix]) begin
                        nv[ix] = cdb_val[c*32 +: 32];
                        nd[ix] = '0;
                    end
                end
                if (inst_valid && push_valid && rd != 0) nd[rd] = rd_tag;
            end
        end
        pop = 0;
        for (int i = 0; i < 32; i++) if (nd[i] != 0) pop++;
        @(posedge clk_in);
        #1;
        m_val = nv;
        m_dep = nd;
        chk("pending_cnt", 64'(pending_cnt), 64'(pop));
        chk("all_clear", 64'(all_clear), 64'(pop == 0));
    endtask

    initial begin
        clr_in();
        rst_in = 1'b0;
        model_reset();
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        #1;
        chk("rst_vj", vj, 0);
        chk("rst_qj", qj, 0);
        chk("rst_pending", pending_cnt, 0);
        chk("rst_all_clear", all_clear, 1);

        // rename x5 then write back through ch0
        clr_in(); push(5, 3); rs1 = 5;
        cycle();
        clr_in(); inst_valid = 1'b1; rs1 = 5;
        #1 chk("ren_qj", qj, 3);
        set_cdb(0, 1'b1, 4'd3, 32'hDEAD, 5'd5);
        #1 chk("byp_vj", vj, 32'hDEAD);
        chk("byp_qj", qj, 0);
        cycle();
        clr_in(); inst_valid = 1'b1; rs1 = 5;
        #1 chk("wb_vj", vj, 32'hDEAD);
        chk("wb_pending", pending_cnt, 0);
        cycle();

        // rename/clear collision on x7
        clr_in(); push(7, 2);
        cycle();
        clr_in(); push(7, 4); set_cdb(0, 1'b1, 4'd2, 32'h77, 5'd7);
        cycle();
        chk("coll_pending", pending_cnt, 1);
        clr_in(); inst_valid = 1'b1; rs1 = 7;
        #1 chk("coll_qj", qj, 4);
        cycle();

        // two channels into x9: matching tag wins, then higher channel wins
        clr_in(); push(9, 6);
        cycle();
        clr_in();
        set_cdb(0, 1'b1, 4'd5, 32'h11, 5'd9);
        set_cdb(1, 1'b1, 4'd6, 32'h22, 5'd9);
        cycle();
        clr_in(); inst_valid = 1'b1; rs1 = 9;
        #1 chk("dual_match_vj", vj, 32'h22);
        chk("dual_match_qj", qj, 0);
        cycle();
        clr_in();
        set_cdb(0, 1'b1, 4'd1, 32'h33, 5'd9);
        set_cdb(1, 1'b1, 4'd2, 32'h44, 5'd9);
        cycle();
        clr_in(); inst_valid = 1'b1; rs1 = 9;
        #1 chk("dual_high_vj", vj, 32'h44);
        cycle();

        // frozen flush leaves everything, enabled flush clears deps only
        for (int r = 1; r <= 4; r++) begin
            clr_in(); push(5'(r), 4'(r));
            cycle();
        end
        clr_in(); rdy_in = 1'b0; predict_fail = 1'b1; push(6, 5);
        set_cdb(0, 1'b1, 4'd1, 32'hAB, 5'd1);
        cycle();
        chk("freeze_pending", pending_cnt, 5);
        clr_in(); predict_fail = 1'b1; push(6, 5);
        set_cdb(0, 1'b1, 4'd1, 32'hAB, 5'd1);
        cycle();
        chk("flush_pending", pending_cnt, 0);
        chk("flush_all_clear", all_clear, 1);
        clr_in(); inst_valid = 1'b1; rs1 = 1; rs2 = 7;
        #1 chk("flush_vj", vj, 0);
        chk("flush_qj", qj, 0);
        chk("flush_vk", vk, 32'h77);
        cycle();

        // x0 is never renamed or written
        clr_in(); push(0, 8); set_cdb(0, 1'b1, 4'd8, 32'hFF, 5'd0);
        cycle();
        clr_in(); inst_valid = 1'b1; rs1 = 0;
        #1 chk("x0_vj", vj, 0);
        chk("x0_qj", qj, 0);
        chk("x0_pending", pending_cnt, 0);
        cycle();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            clr_in();
            rdy_in       = ($urandom_range(0, 7) != 0);
            predict_fail = ($urandom_range(0, 31) == 0);
            inst_valid   = ($urandom_range(0, 3) != 0);
            push_valid   = 1'($urandom_range(0, 1));
            rd           = 5'($urandom_range(0, 11));
            rs1          = 5'($urandom_range(0, 11));
            rs2          = 5'($urandom_range(0, 11));
            rd_tag       = 4'($urandom_range(1, 15));
            for (int c = 0; c < 2; c++) begin
                logic [3:0] t;
                logic [4:0] ix;
                logic       a;
                int         r;
                t = 4'($urandom_range(1, 15));
                ix = 5'($urandom_range(0, 11));
                a = 1'($urandom_range(0, 1));
                r = $urandom_range(0, 11);
                if ($urandom_range(0, 2) != 0 && m_dep[r] != 0) begin
                    t = m_dep[r];
                    ix = 5'(r);
                end
                if (c == 1 && cdb_active[0] && cdb_tag[3:0] == t) a = 1'b0;
                set_cdb(c, a, t, $urandom, ix);
            end
            cycle();
        end

        // asynchronous reset mid-run with x5 pending
        clr_in(); push(5, 9);
        cycle();
        #2 rst_in = 1'b0;
        model_reset();
        #1;
        chk("mrst_pending", pending_cnt, 0);
        chk("mrst_all_clear", all_clear, 1);
        chk("mrst_idle_vj", vj, 0);
        chk("mrst_idle_qj", qj, 0);
        @(posedge clk_in);
        #1 rst_in = 1'b1;
        clr_in(); inst_valid = 1'b1; rs1 = 5;
        #1 chk("mrst_qj", qj, 0);
        chk("mrst_vj", vj, 0);
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_multi_cdb.md
# regfile_multi_cdb

Parametrised successor to the current architectural register file with rename-tag (dependency) table. It sits between the issue stage (RS/LSB dispatch) and the common data buses. It adds:
- `NCDB` independent write-back channels;
- same-cycle CDB-to-read bypass;
- a registered pending-dependency count;
- fully specified collision rules.

A branch mispredict flushes all dependencies while keeping architectural values.

## Interface
Parameters:
- `XLEN`, 32, data width
- `NREG`, 32, architectural registers; index width `RW = $clog2(NREG)`
- `TAG_W`, 4, rename tag width; tag 0 = None (no dependency)
- `NCDB`, 2, number of CDB write-back channels (1..4)

Ports:
- `clk_in` in 1: single clock, rising edge
- `rst_in` in 1: asynchronous, active-low reset
- `rdy_in` in 1: global enable; low freezes all state
- `inst_valid` in 1: issue-stage read/rename request valid
- `push_valid` in 1: instruction accepted into RS/LSB; rename `rd` this cycle
- `rd`, `rs1`, `rs2` in RW each: destination and source indices
- `rd_tag` in TAG_W: tag assigned to `rd`; must be non-zero when pushed
- `cdb_active` in NCDB: per-channel valid
- `cdb_tag` in NCDB*TAG_W: per-channel producing tag, packed with channel 0 in the LSBs
- `cdb_val` in NCDB*XLEN: per-channel result
- `cdb_rd_idx` in NCDB*RW: per-channel destination register
- `predict_fail` in 1: flush request
- `vj`, `vk` out XLEN: source values
- `qj`, `qk` out TAG_W: source tags
- `pending_cnt` out $clog2(NREG+1): registered count of registers with a non-None tag
- `all_clear` out 1: `pending_cnt == 0`

## Operation
State:
- `val[NREG]` XLEN-bit values
- `dep[NREG]` TAG_W-bit tags
- `pending_cnt`

Reads (combinational), evaluated per source `s` in {rs1, rs2}:
- `inst_valid` = 0: output q = None and v = 0.
- `s` = 0: output q = None and v = 0.
- `dep[s]` = None: output q = None and v = `val[s]`.
- `dep[s]` ≠ None and some active channel c has `cdb_tag[c] == dep[s]` (bypass): output q = None and v = `cdb_val[c]`. Tags on different channels are unique within a cycle.
- Otherwise: output q = `dep[s]` and v = 0.
- Reads always see pre-rename state. An instruction with `rs1 == rd` gets the previous producer, not itself.

Writes (on rising edge, when `rdy_in` = 1 and `predict_fail` = 0):
- **CDB value write.** For each active channel with `cdb_rd_idx` ≠ 0, write `val[cdb_rd_idx] <= cdb_val`.
  - Two channels targeting the same index: the channel whose tag equals `dep[idx]` wins.
  - If neither tag matches, the higher channel index wins.
- **CDB tag clear.** `dep[idx] <= None` if an active channel matches both idx and `dep[idx]`.
- **Rename.** If `inst_valid & push_valid & rd != 0`: `dep[rd] <= rd_tag`.
  - Rename has priority over a same-cycle clear of the same register.
  - The value write still occurs.
- Register 0: `val[0]` and `dep[0]` always read as 0/None and are never written.

Flush and freeze:
- **Flush.** `predict_fail` = 1 and `rdy_in` = 1:
  - All `dep` become None.
  - `val` is unchanged; CDB and rename inputs are ignored this cycle.
  - `pending_cnt <= 0`.
- **Freeze.** `rdy_in` = 0: no state changes, including on flush. Combinational outputs still track the inputs.

Pending count:
- `pending_cnt` is the popcount of the next-state `dep` table, registered every enabled cycle.
- It therefore equals the popcount of the current `dep` table.

## Timing
- Read latency is 0 cycles (combinational from `rs*`, `dep`, `val`, CDB).
- Write latency is 1 cycle: a CDB value is visible in `val` the cycle after `cdb_active`. It is also visible in the same cycle through the bypass.
- A rename is visible in `qj`/`qk` the cycle after push.
- `pending_cnt` and `all_clear` lag the table update by 0 cycles (both are registers).
- Reset (`rst_in` low, asynchronous) sets:
  - all `val` to 0 and all `dep` to None;
  - `pending_cnt` to 0 and `all_clear` to 1.
  - With `inst_valid` = 0, `vj`/`vk` = 0 and `qj`/`qk` = None.
- Reset asserted mid-operation overrides everything in the same instant. After release, the first rising edge with `rdy_in` = 1 is operative.

## Structure
- Shared package `rf_pkg`:
  - `TAG_NONE = '0`
  - default `XLEN`, `TAG_W`, `NREG`
  - CDB channel slice helper functions (tag/value/index extraction)
- Sub-module `rf_read_port` (one source: dep lookup, CDB bypass match, v/q mux), instantiated twice.
- Top level holds the tables, the write priority logic and the popcount.

## Test plan
- **Reset:** assert `rst_in` = 0 mid-run → read x5 after release gives qj = 0, vj = 0, `pending_cnt` = 0, `all_clear` = 1.
- **Rename then write-back:** push rd = 5, tag = 3 → next cycle rs1 = 5 gives qj = 3. Ch0 CDB tag 3, val 0xDEAD, idx 5 → same cycle vj = 0xDEAD (bypass), qj = 0. Next cycle `val[5]` = 0xDEAD, `pending_cnt` = 0.
- **Rename/clear collision:** x7 has dep 2; same cycle CDB tag 2 idx 7 and push rd = 7 tag 4 → `dep[7]` = 4, `val[7]` = CDB value, `pending_cnt` unchanged at 1.
- **Dual CDB same index:** dep[9] = 6; ch0 tag 5 val 0x11 idx 9, ch1 tag 6 val 0x22 idx 9 → `val[9]` = 0x22, dep[9] = None. Repeat with neither tag matching → higher channel (ch1) value written.
- **Flush:** deps on x1..x4, then `predict_fail` with a concurrent CDB and push → all deps None, `val` unchanged, `pending_cnt` = 0. With `rdy_in` = 0 the same stimulus leaves the state untouched.
- **x0:** push rd = 0 tag 8, CDB idx 0 val 0xFF → reading rs1 = 0 gives qj = None, vj = 0; `pending_cnt` unchanged.
